// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_t     : controller state encoding
//   bcd_time_t  : MM:SS.t as five packed BCD digits
//   DIGIT_W     : width of one BCD digit
//   LIM_*       : per-digit wrap limits
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned LIM_T   = 9;
    localparam int unsigned LIM_S1  = 9;
    localparam int unsigned LIM_S10 = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] m10;
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] s10;
        logic [DIGIT_W-1:0] s1;
        logic [DIGIT_W-1:0] t;
    } bcd_time_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter with wrap limit.
//   clock, reset_n : clock, async active-low reset
//   en             : count one step this cycle
//   clr            : synchronous zero, wins over en
//   q              : current digit
//   carry_c        : combinational, high when en and the digit wraps
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned LIMIT = 9
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_c
);

    localparam logic [DIGIT_W-1:0] LIM = DIGIT_W'(LIMIT);

    assign carry_c = en && (q == LIM);

    // Digit register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LIM) ? '0 : q + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller holding MM:SS.t as BCD digits.
//   clock, reset_n    : clock, async active-low reset
//   tick              : 100 ms pulse from the divider
//   btn_start_stop,
//   btn_lap, btn_clear: debounced one-cycle button pulses
//   div_clear         : combinational divider phase restart (IDLE -> RUN)
//   disp_*            : displayed digits (lap register in LAP, else count)
//   running, lap_hold : state flags
//   rollover          : one-cycle pulse after wrap from MIN_MAX:59.9
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = 59
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    output logic               div_clear,
    output logic [DIGIT_W-1:0] disp_m10,
    output logic [DIGIT_W-1:0] disp_m1,
    output logic [DIGIT_W-1:0] disp_s10,
    output logic [DIGIT_W-1:0] disp_s1,
    output logic [DIGIT_W-1:0] disp_t,
    output logic               running,
    output logic               lap_hold,
    output logic               rollover
);

    localparam logic [DIGIT_W-1:0] MAX_M10 = DIGIT_W'(MIN_MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_M1  = DIGIT_W'(MIN_MAX % 10);

    state_t    state_q, state_d;
    bcd_time_t count, lap_q, shown;
    logic      inc_c, cnt_clr_c, lap_load_c, at_max_c, wrap_c, digit_clr_c;
    logic      c_t, c_s1, c_s10, c_m1, m10_carry_unused;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; start_stop beats lap, clear beats start_stop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (btn_start_stop) state_d = ST_RUN;
            ST_RUN:   if (btn_start_stop) state_d = ST_PAUSE;
                      else if (btn_lap)   state_d = ST_LAP;
            ST_LAP:   if (btn_start_stop) state_d = ST_PAUSE;
                      else if (btn_lap)   state_d = ST_RUN;
            ST_PAUSE: if (btn_clear)      state_d = ST_IDLE;
                      else if (btn_start_stop) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-cycle control strobes decoded from the current state
    always_comb begin
        div_clear  = 1'b0;
        inc_c      = 1'b0;
        cnt_clr_c  = 1'b0;
        lap_load_c = 1'b0;
        unique case (state_q)
            ST_IDLE:  div_clear  = btn_start_stop;
            ST_RUN:   begin
                inc_c      = tick;
                lap_load_c = btn_lap && !btn_start_stop;
            end
            ST_LAP:   inc_c      = tick;
            ST_PAUSE: cnt_clr_c  = btn_clear;
            default:  ;
        endcase
    end

    // Wrap at MIN_MAX:59.9 is a synchronous clear of the whole chain
    assign at_max_c    = (count.m10 == MAX_M10) && (count.m1 == MAX_M1) &&
                         (count.s10 == DIGIT_W'(LIM_S10)) &&
                         (count.s1 == DIGIT_W'(LIM_S1)) &&
                         (count.t == DIGIT_W'(LIM_T));
    assign wrap_c      = inc_c && at_max_c;
    assign digit_clr_c = cnt_clr_c || wrap_c;

    bcd_digit_counter #(.LIMIT(LIM_T)) u_t (
        .clock(clock), .reset_n(reset_n), .en(inc_c), .clr(digit_clr_c),
        .q(count.t), .carry_c(c_t)
    );
    bcd_digit_counter #(.LIMIT(LIM_S1)) u_s1 (
        .clock(clock), .reset_n(reset_n), .en(c_t), .clr(digit_clr_c),
        .q(count.s1), .carry_c(c_s1)
    );
    bcd_digit_counter #(.LIMIT(LIM_S10)) u_s10 (
        .clock(clock), .reset_n(reset_n), .en(c_s1), .clr(digit_clr_c),
        .q(count.s10), .carry_c(c_s10)
    );
    // Minutes run as a plain 00..99 BCD pair; the MIN_MAX bound comes from wrap_c
    bcd_digit_counter #(.LIMIT(9)) u_m1 (
        .clock(clock), .reset_n(reset_n), .en(c_s10), .clr(digit_clr_c),
        .q(count.m1), .carry_c(c_m1)
    );
    bcd_digit_counter #(.LIMIT(9)) u_m10 (
        .clock(clock), .reset_n(reset_n), .en(c_m1), .clr(digit_clr_c),
        .q(count.m10), .carry_c(m10_carry_unused)
    );

    // Status flags, rollover pulse and lap register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running  <= 1'b0;
            lap_hold <= 1'b0;
            rollover <= 1'b0;
            lap_q    <= '0;
        end else begin
            running  <= (state_d == ST_RUN) || (state_d == ST_LAP);
            lap_hold <= (state_d == ST_LAP);
            rollover <= wrap_c;
            if (lap_load_c) lap_q <= count;
        end
    end

    // Display mux
    assign shown    = lap_hold ? lap_q : count;
    assign disp_m10 = shown.m10;
    assign disp_m1  = shown.m1;
    assign disp_s10 = shown.s10;
    assign disp_s1  = shown.s1;
    assign disp_t   = shown.t;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed test-plan steps then random traffic,
// compared against a model that keeps elapsed time as an integer number of tenths.
module tb_stopwatch_ctrl;

    localparam int unsigned MIN_MAX = 59;
    localparam int WRAP_TENTHS = (MIN_MAX + 1) * 600;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0, btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic       div_clear, running, lap_hold, rollover;
    logic [3:0] disp_m10, disp_m1, disp_s10, disp_s1, disp_t;
    logic [19:0] disp;

    int checks = 0;
    int errors = 0;

    int m_state, m_cnt, m_lap;
    bit m_roll;

    assign disp = {disp_m10, disp_m1, disp_s10, disp_s1, disp_t};

    always #5 clock = ~clock;

    stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .div_clear(div_clear),
        .disp_m10(disp_m10), .disp_m1(disp_m1), .disp_s10(disp_s10),
        .disp_s1(disp_s1), .disp_t(disp_t),
        .running(running), .lap_hold(lap_hold), .rollover(rollover)
    );

    function automatic logic [19:0] bcd_of(input int tenths);
        int m, s, t;
        m = tenths / 600;
        s = (tenths / 10) % 60;
        t = tenths % 10;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_lap   = 0;
        m_roll  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("disp", disp, bcd_of((m_state == M_LAP) ? m_lap : m_cnt));
        chk("running", 20'(running), 20'((m_state == M_RUN) || (m_state == M_LAP)));
        chk("lap_hold", 20'(lap_hold), 20'(m_state == M_LAP));
        chk("rollover", 20'(rollover), 20'(m_roll));
    endtask

    // One clock cycle with the given inputs; called at posedge+1, returns at posedge+1
    task automatic step(input bit tk, input bit ss, input bit lp, input bit cl);
        int  nst;
        bit  inc;
        tick = tk; btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
        #1;
        chk("div_clear", 20'(div_clear), 20'((m_state == M_IDLE) && ss));
        @(posedge clock);
        #1;
        inc    = tk && ((m_state == M_RUN) || (m_state == M_LAP));
        nst    = m_state;
        m_roll = 1'b0;
        case (m_state)
            M_IDLE:  if (ss) nst = M_RUN;
            M_RUN:   if (ss) nst = M_PAUSE;
                     else if (lp) begin nst = M_LAP; m_lap = m_cnt; end
            M_LAP:   if (ss) nst = M_PAUSE;
                     else if (lp) nst = M_RUN;
            default: if (cl) begin nst = M_IDLE; m_cnt = 0; end
                     else if (ss) nst = M_RUN;
        endcase
        if (inc) begin
            m_cnt++;
            if (m_cnt == WRAP_TENTHS) begin m_cnt = 0; m_roll = 1'b1; end
        end
        m_state = nst;
        tick = 1'b0; btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_disp", disp, 20'h00000);
        chk("reset_flags", 20'({running, lap_hold, rollover, div_clear}), 20'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Start, 125 ticks
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(125);
        chk("disp_12_5", disp, 20'h00125);
        chk("run_12_5", 20'(running), 20'h1);

        // Lap freeze at 00:03.4, release at 00:05.4
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(34);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(20);
        chk("lap_frozen", disp, 20'h00034);
        chk("lap_hold_on", 20'(lap_hold), 20'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_release", disp, 20'h00054);

        // Tick coinciding with stop is counted
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("stop_tick", disp, 20'h00010);
        ticks(5);
        chk("pause_hold", disp, 20'h00010);
        chk("pause_running", 20'(running), 20'h0);

        // Clear and start_stop together in PAUSE
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_disp", disp, 20'h00000);

        // Run to 59:59.9 and wrap
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(WRAP_TENTHS - 1);
        chk("at_max", disp, 20'h59599);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_disp", disp, 20'h00000);
        chk("wrap_pulse", 20'(rollover), 20'h1);
        chk("wrap_running", 20'(running), 20'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pulse_end", 20'(rollover), 20'h0);

        // Async reset while in LAP
        ticks(7);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("lap_before_rst", disp, 20'h00007);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_disp", disp, 20'h00000);
        chk("async_rst_flags", 20'({running, lap_hold, rollover}), 20'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_idle", 20'(running), 20'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
